// File: rtl/usb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// usb_ctrl_pkg
// Shared definitions for the controller serial link (receiver and transmitter):
//   - operation nibbles for the four buttons
//   - coordinates the cursor starts from after reset
//   - receiver FSM state encoding
//   - bit positions inside the one-hot dir {L,R,U,D} and btn {A,B,X,Y} vectors
// -----------------------------------------------------------------------------
package usb_ctrl_pkg;

   localparam logic [3:0] OP_A = 4'b1001;
   localparam logic [3:0] OP_B = 4'b1011;
   localparam logic [3:0] OP_X = 4'b1101;
   localparam logic [3:0] OP_Y = 4'b1111;

   localparam logic [3:0] X0 = 4'd10;
   localparam logic [3:0] Y0 = 4'd8;

   localparam int FRAME_BITS = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } rx_state_t;

   localparam int DIR_L = 3;
   localparam int DIR_R = 2;
   localparam int DIR_U = 1;
   localparam int DIR_D = 0;

   localparam int BTN_A = 3;
   localparam int BTN_B = 2;
   localparam int BTN_X = 1;
   localparam int BTN_Y = 0;

endpackage

// File: rtl/usb_serial_receiver_if.sv
// -----------------------------------------------------------------------------
// usb_serial_receiver_if
// Serial link bundle between the controller side and the host-side receiver.
//   bit_valid/cord_bit/op_bit : serial input, driven by the link (master)
//   x_out/y_out/op_out        : last received position and op nibble
//   dir/btn                   : one-hot move {L,R,U,D} / button {A,B,X,Y}
//   frame_valid/frame_err     : one-cycle frame strobe and malformed flag
//   timeout                   : one-cycle pulse when a partial frame is dropped
// -----------------------------------------------------------------------------
interface usb_serial_receiver_if;
   logic       bit_valid;
   logic       cord_bit;
   logic       op_bit;
   logic [3:0] x_out;
   logic [3:0] y_out;
   logic [3:0] op_out;
   logic [3:0] dir;
   logic [3:0] btn;
   logic       frame_valid;
   logic       frame_err;
   logic       timeout;

   modport master (
      output bit_valid, cord_bit, op_bit,
      input  x_out, y_out, op_out, dir, btn, frame_valid, frame_err, timeout
   );

   modport slave (
      input  bit_valid, cord_bit, op_bit,
      output x_out, y_out, op_out, dir, btn, frame_valid, frame_err, timeout
   );
endinterface

// File: rtl/usb_frame_classify.sv
// -----------------------------------------------------------------------------
// usb_frame_classify
// Combinational classification of a completed frame against the held position.
//   i_prev_x/i_prev_y : position held before this frame
//   i_new_x/i_new_y   : position carried by this frame
//   i_op              : op nibble, i_trail : trailing op bits (must be zero)
//   o_dir             : one-hot {L,R,U,D} for a single-step move
//   o_btn             : one-hot {A,B,X,Y} for a button frame
//   o_err             : frame malformed (dir/btn forced to zero)
// -----------------------------------------------------------------------------
module usb_frame_classify
   import usb_ctrl_pkg::*;
(
   input  logic [3:0] i_prev_x,
   input  logic [3:0] i_prev_y,
   input  logic [3:0] i_new_x,
   input  logic [3:0] i_new_y,
   input  logic [3:0] i_op,
   input  logic [3:0] i_trail,
   output logic [3:0] o_dir,
   output logic [3:0] o_btn,
   output logic       o_err
);

   // 4-bit arithmetic gives the 0<->15 wrap for free
   logic [3:0] w_x_inc, w_x_dec, w_y_inc, w_y_dec;
   logic       w_x_same, w_y_same;

   assign w_x_inc  = i_prev_x + 4'd1;
   assign w_x_dec  = i_prev_x - 4'd1;
   assign w_y_inc  = i_prev_y + 4'd1;
   assign w_y_dec  = i_prev_y - 4'd1;
   assign w_x_same = (i_new_x == i_prev_x);
   assign w_y_same = (i_new_y == i_prev_y);

   always_comb begin
      o_dir = '0;
      o_btn = '0;
      o_err = 1'b0;
      if (i_trail != 4'd0) begin
         o_err = 1'b1;
      end else if (w_x_same && w_y_same) begin
         case (i_op)
            OP_A:    o_btn[BTN_A] = 1'b1;
            OP_B:    o_btn[BTN_B] = 1'b1;
            OP_X:    o_btn[BTN_X] = 1'b1;
            OP_Y:    o_btn[BTN_Y] = 1'b1;
            default: o_err        = 1'b1;
         endcase
      end else if (w_y_same && (i_new_x == w_x_dec)) begin
         o_dir[DIR_L] = 1'b1;
      end else if (w_y_same && (i_new_x == w_x_inc)) begin
         o_dir[DIR_R] = 1'b1;
      end else if (w_x_same && (i_new_y == w_y_inc)) begin
         o_dir[DIR_U] = 1'b1;
      end else if (w_x_same && (i_new_y == w_y_dec)) begin
         o_dir[DIR_D] = 1'b1;
      end else begin
         o_err = 1'b1;
      end
   end

endmodule

// File: rtl/usb_serial_receiver.sv
// -----------------------------------------------------------------------------
// usb_serial_receiver
// Deserialises the coordinate and operation bit streams into 8-bit frames,
// MSB first, and publishes the decoded position / move / button per frame.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of usb_serial_receiver_if (serial in, decoded out)
//   TIMEOUT    : idle cycles tolerated between bits inside a frame
// -----------------------------------------------------------------------------
module usb_serial_receiver
   import usb_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   usb_serial_receiver_if.slave bus
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   rx_state_t         r_state, w_state_next;
   logic [2:0]        r_bit_cnt, w_bit_cnt_next;
   logic [6:0]        r_cord_sh, w_cord_sh_next;
   logic [6:0]        r_op_sh, w_op_sh_next;
   logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_next;

   logic [3:0] r_x, r_y, r_op, r_dir, r_btn;
   logic [3:0] w_x_next, w_y_next, w_op_next, w_dir_next, w_btn_next;
   logic       r_fv, r_err, r_to;
   logic       w_fv_next, w_err_next, w_to_next;

   logic       w_commit, w_expire;
   logic [7:0] w_frame_cord, w_frame_op;
   logic [3:0] w_cls_dir, w_cls_btn;
   logic       w_cls_err;

   // The 8th bit is still on the pins when the frame commits
   assign w_frame_cord = {r_cord_sh, bus.cord_bit};
   assign w_frame_op   = {r_op_sh, bus.op_bit};

   assign w_commit = (r_state == ST_RECV) && bus.bit_valid &&
                     (r_bit_cnt == 3'(FRAME_BITS - 1));
   // A bit arriving on the expiring cycle wins, hence the !bit_valid term
   assign w_expire = (r_state == ST_RECV) && !bus.bit_valid &&
                     (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

   usb_frame_classify u_classify (
      .i_prev_x (r_x),
      .i_prev_y (r_y),
      .i_new_x  (w_frame_cord[7:4]),
      .i_new_y  (w_frame_cord[3:0]),
      .i_op     (w_frame_op[7:4]),
      .i_trail  (w_frame_op[3:0]),
      .o_dir    (w_cls_dir),
      .o_btn    (w_cls_btn),
      .o_err    (w_cls_err)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.bit_valid)         w_state_next = ST_RECV;
         ST_RECV: if (w_commit || w_expire)  w_state_next = ST_IDLE;
         default:                            w_state_next = ST_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      w_bit_cnt_next  = r_bit_cnt;
      w_cord_sh_next  = r_cord_sh;
      w_op_sh_next    = r_op_sh;
      w_idle_cnt_next = r_idle_cnt;
      w_x_next        = r_x;
      w_y_next        = r_y;
      w_op_next       = r_op;
      w_dir_next      = r_dir;
      w_btn_next      = r_btn;
      w_fv_next       = 1'b0;
      w_err_next      = 1'b0;
      w_to_next       = 1'b0;
      if (bus.bit_valid) begin
         w_cord_sh_next  = {r_cord_sh[5:0], bus.cord_bit};
         w_op_sh_next    = {r_op_sh[5:0], bus.op_bit};
         w_idle_cnt_next = '0;
         if (w_commit) begin
            w_bit_cnt_next = '0;
            w_x_next       = w_frame_cord[7:4];
            w_y_next       = w_frame_cord[3:0];
            w_op_next      = w_frame_op[7:4];
            w_dir_next     = w_cls_dir;
            w_btn_next     = w_cls_btn;
            w_err_next     = w_cls_err;
            w_fv_next      = 1'b1;
         end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
         end
      end else if (r_state == ST_RECV) begin
         if (w_expire) begin
            w_bit_cnt_next  = '0;
            w_cord_sh_next  = '0;
            w_op_sh_next    = '0;
            w_idle_cnt_next = '0;
            w_to_next       = 1'b1;
         end else begin
            w_idle_cnt_next = r_idle_cnt + IDLE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_cnt  <= '0;
         r_cord_sh  <= '0;
         r_op_sh    <= '0;
         r_idle_cnt <= '0;
         r_x        <= X0;
         r_y        <= Y0;
         r_op       <= '0;
         r_dir      <= '0;
         r_btn      <= '0;
         r_fv       <= 1'b0;
         r_err      <= 1'b0;
         r_to       <= 1'b0;
      end else begin
         r_bit_cnt  <= w_bit_cnt_next;
         r_cord_sh  <= w_cord_sh_next;
         r_op_sh    <= w_op_sh_next;
         r_idle_cnt <= w_idle_cnt_next;
         r_x        <= w_x_next;
         r_y        <= w_y_next;
         r_op       <= w_op_next;
         r_dir      <= w_dir_next;
         r_btn      <= w_btn_next;
         r_fv       <= w_fv_next;
         r_err      <= w_err_next;
         r_to       <= w_to_next;
      end
   end

   assign bus.x_out       = r_x;
   assign bus.y_out       = r_y;
   assign bus.op_out      = r_op;
   assign bus.dir         = r_dir;
   assign bus.btn         = r_btn;
   assign bus.frame_valid = r_fv;
   assign bus.frame_err   = r_err;
   assign bus.timeout     = r_to;

endmodule

// File: tb/tb_usb_serial_receiver.sv
// -----------------------------------------------------------------------------
// tb_usb_serial_receiver
// Directed frames with hand-computed expected position / move / button values.
// -----------------------------------------------------------------------------
module tb_usb_serial_receiver;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   usb_serial_receiver_if bus_if();

   usb_serial_receiver #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Pulse monitor, sampled on the falling edge
   int cyc     = 0;
   int fv_cnt  = 0;
   int fv_last = 0;
   int fv_prev = 0;
   int to_cnt  = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bus_if.frame_valid) begin
         fv_cnt  <= fv_cnt + 1;
         fv_prev <= fv_last;
         fv_last <= cyc;
      end
      if (bus_if.timeout) to_cnt <= to_cnt + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic c, input logic o);
      bus_if.bit_valid = 1'b1;
      bus_if.cord_bit  = c;
      bus_if.op_bit    = o;
      step();
      bus_if.bit_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] o);
      for (int i = 7; i >= 0; i--) send_bit(c[i], o[i]);
   endtask

   task automatic check_outs(input string tag, input int x, input int y,
                             input int op, input int dir, input int btn);
      check({tag, ".x"},   int'(bus_if.x_out),  x);
      check({tag, ".y"},   int'(bus_if.y_out),  y);
      check({tag, ".op"},  int'(bus_if.op_out), op);
      check({tag, ".dir"}, int'(bus_if.dir),    dir);
      check({tag, ".btn"}, int'(bus_if.btn),    btn);
   endtask

   // Called right after the 8th bit edge: checks the committed frame, then the
   // pulse ending one cycle later
   task automatic expect_frame(input string tag, input int x, input int y,
                               input int op, input int dir, input int btn,
                               input int err);
      check({tag, ".fv"},  int'(bus_if.frame_valid), 1);
      check({tag, ".err"}, int'(bus_if.frame_err),   err);
      check_outs(tag, x, y, op, dir, btn);
      $display("frame %s: x=%0d y=%0d op=%b dir=%b btn=%b err=%0d", tag,
               bus_if.x_out, bus_if.y_out, bus_if.op_out, bus_if.dir,
               bus_if.btn, bus_if.frame_err);
      step();
      check({tag, ".fv_end"},  int'(bus_if.frame_valid), 0);
      check({tag, ".err_end"}, int'(bus_if.frame_err),   0);
   endtask

   int fv_snap;
   int to_snap;

   initial begin
      bus_if.bit_valid = 1'b0;
      bus_if.cord_bit  = 1'b0;
      bus_if.op_bit    = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      step();

      check("rst.fv",  int'(bus_if.frame_valid), 0);
      check("rst.err", int'(bus_if.frame_err),   0);
      check("rst.to",  int'(bus_if.timeout),     0);
      check_outs("rst", 10, 8, 0, 0, 0);

      // Moves and buttons
      send_frame(8'b1001_1000, 8'b0000_0000); expect_frame("move_l",  9, 8,  0, 8, 0, 0);
      send_frame(8'b1010_1000, 8'b0000_0000); expect_frame("move_r", 10, 8,  0, 4, 0, 0);
      send_frame(8'b1010_1000, 8'b1101_0000); expect_frame("btn_x",  10, 8, 13, 0, 2, 0);
      send_frame(8'b1010_1000, 8'b1001_0000); expect_frame("btn_a",  10, 8,  9, 0, 8, 0);
      send_frame(8'b1111_1000, 8'b0000_0000); expect_frame("jump",   15, 8,  0, 0, 0, 1);
      send_frame(8'b0000_1000, 8'b0000_0000); expect_frame("wrap_r",  0, 8,  0, 4, 0, 0);
      send_frame(8'b1111_1000, 8'b0000_0000); expect_frame("wrap_l", 15, 8,  0, 8, 0, 0);
      send_frame(8'b1111_1001, 8'b0000_0000); expect_frame("move_u", 15, 9,  0, 2, 0, 0);
      send_frame(8'b1111_1000, 8'b0000_0000); expect_frame("move_d", 15, 8,  0, 1, 0, 0);

      // Malformed frames
      send_frame(8'b1010_1000, 8'b0000_0000); expect_frame("far_x",  10, 8,  0, 0, 0, 1);
      send_frame(8'b1011_1001, 8'b0000_0000); expect_frame("diag",   11, 9,  0, 0, 0, 1);
      send_frame(8'b1011_1001, 8'b0110_0000); expect_frame("bad_op", 11, 9,  6, 0, 0, 1);
      send_frame(8'b1011_1001, 8'b1001_0001); expect_frame("trail",  11, 9,  9, 0, 0, 1);
      send_frame(8'b1011_1001, 8'b1011_0000); expect_frame("btn_b",  11, 9, 11, 0, 4, 0);

      // Timeout after 5 bits
      fv_snap = fv_cnt;
      to_snap = to_cnt;
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      for (int i = 0; i < 15; i++) step();
      check("to.early", int'(bus_if.timeout), 0);
      step();
      check("to.pulse", int'(bus_if.timeout), 1);
      check("to.fv",    int'(bus_if.frame_valid), 0);
      check_outs("to.hold", 11, 9, 11, 0, 4);
      $display("timeout pulse: timeout=%0d", bus_if.timeout);
      step();
      check("to.end",   int'(bus_if.timeout), 0);
      check("to.nofv",  fv_cnt - fv_snap, 0);
      check("to.count", to_cnt - to_snap, 1);
      send_frame(8'b1011_1000, 8'b0000_0000); expect_frame("after_to", 11, 8, 0, 1, 0, 0);

      // Bit lands on the cycle that would have expired
      to_snap = to_cnt;
      send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      for (int i = 0; i < 15; i++) step();
      send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
      expect_frame("late_bit", 12, 8, 0, 4, 0, 0);
      check("late_bit.noto", to_cnt - to_snap, 0);

      // Reset mid-frame
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
      reset = 1'b1;
      #2;
      check_outs("midrst", 10, 8, 0, 0, 0);
      check("midrst.fv", int'(bus_if.frame_valid), 0);
      $display("mid-frame reset: x=%0d y=%0d dir=%b", bus_if.x_out, bus_if.y_out, bus_if.dir);
      step();
      reset = 1'b0;
      step();
      send_frame(8'b1001_1000, 8'b0000_0000); expect_frame("post_rst", 9, 8, 0, 8, 0, 0);

      // Back-to-back frames, zero gap
      fv_snap = fv_cnt;
      send_frame(8'b1010_1000, 8'b0000_0000);
      send_frame(8'b1011_1000, 8'b0000_0000);
      step();
      check("b2b.count",   fv_cnt - fv_snap, 2);
      check("b2b.spacing", fv_last - fv_prev, 8);
      check_outs("b2b", 11, 8, 0, 4, 0);
      $display("back-to-back: pulses=%0d spacing=%0d", fv_cnt - fv_snap, fv_last - fv_prev);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/usb_serial_receiver.md
# usb_serial_receiver

Receive end of the controller's serial link. Deserialises the two 1-bit streams (coordinate, operation) into 8-bit frames, reconstructs X/Y position and button code, and classifies each frame as a one-step move (L/R/U/D) or a button press (A/B/X/Y). It sits on the host side of the link and feeds decoded events to the application logic with a one-cycle `frame_valid` strobe.

## Interface
- `TIMEOUT`, default 16: idle cycles allowed between bits inside a frame before the partial frame is dropped.
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `bit_valid` input 1: qualifies `cord_bit`/`op_bit` this cycle.
- `cord_bit` input 1: serial coordinate bit.
- `op_bit` input 1: serial operation bit.
- `x_out` output 4: last received X (reset 4'd10).
- `y_out` output 4: last received Y (reset 4'd8).
- `op_out` output 4: last received op nibble (reset 0).
- `dir` output 4: {L,R,U,D} one-hot move of last frame (reset 0).
- `btn` output 4: {A,B,X,Y} one-hot button of last frame (reset 0).
- `frame_valid` output 1: one-cycle pulse, frame complete (reset 0).
- `frame_err` output 1: one-cycle pulse with `frame_valid` if frame malformed (reset 0).
- `timeout` output 1: one-cycle pulse, partial frame dropped (reset 0).

## Operation
- Frame = 8 qualified bits, MSB first. Coordinate bit k: k=0..3 -> X[3-k], k=4..7 -> Y[7-k]. Op bit k: k=0..3 -> op[3-k]; k=4..7 must be 0.
- FSM: IDLE (bit_cnt=0) -> RECV on first `bit_valid`; RECV counts bits 1..7; 8th bit -> commit, back to IDLE. Bits are only sampled when `bit_valid`=1; gaps permitted.
- Commit (edge sampling the 8th bit): compare new X/Y with held `x_out`/`y_out` (mod 16):
  - X = prev-1 and Y same -> dir=L (1000); X+1 -> R (0100); Y+1 -> U (0010); Y-1 -> D (0001). Wrap: 0 -> 15 is L, 15 -> 0 is R. btn=0; op nibble ignored.
  - X,Y unchanged -> button frame: op 1001 -> A, 1011 -> B, 1101 -> X, 1111 -> Y (btn one-hot 1000/0100/0010/0001), dir=0.
  - Error: both axes changed, or any axis changed by other than ±1, or unchanged coords with op not in the four codes, or nonzero trailing op bits -> `frame_err`=1, dir=btn=0.
  - In all cases `x_out`/`y_out`/`op_out` load received values (resync) and `frame_valid` pulses.
- Timeout: in RECV, idle counter resets on each `bit_valid`; reaching TIMEOUT consecutive idle cycles -> `timeout` pulse, shift regs and bit_cnt cleared, IDLE; outputs unchanged.
- `bit_valid` on same cycle as timeout expiry: bit wins, counter resets, no timeout.
- Reset mid-frame: partial frame discarded, all outputs to reset values.

## Timing
- Outputs registered; `frame_valid`, `x_out`, `y_out`, `op_out`, `dir`, `btn`, `frame_err` update on the edge sampling bit 7; visible the following cycle.
- Minimum frame = 8 consecutive cycles; back-to-back frames with no gap supported (bit 0 of next frame may arrive the cycle after bit 7).
- `dir`/`btn`/`op_out` hold until next commit; pulses last exactly one cycle.
- Idle counter width = $clog2(TIMEOUT+1).

## Structure
- Shared package `usb_ctrl_pkg`: op codes OP_A=4'b1001, OP_B=4'b1011, OP_X=4'b1101, OP_Y=4'b1111; reset coords X0=4'd10, Y0=4'd8; FSM state enum; dir/btn bit positions. Transmitter uses the same package.
- One sub-module: `usb_frame_classify` (combinational: prev X/Y, new X/Y, op, trailing bits -> dir, btn, err).

## Test plan
- After reset, frame coord 1001_1000, op 0000_0000 -> x_out=9, y_out=8, dir=1000 (L), btn=0, frame_valid 1 cycle, no err.
- From (10,8), frame coord 1010_1000, op 1101_0000 -> btn=0010 (X), dir=0, op_out=1101.
- Wrap: drive X to 15 then frame with X=0, Y same -> dir=0100 (R); X=0 -> 15 -> dir=1000.
- Malformed: (10,8) -> (11,9) -> frame_err=1, dir=btn=0, x_out=11, y_out=9; unchanged coords with op 0110 -> frame_err; op trailing bit 1 -> frame_err.
- Send 5 bits then 16 idle cycles -> timeout pulse on the 16th, no frame_valid, outputs unchanged; next full frame decodes correctly. Bit on the expiring cycle -> no timeout.
- Assert reset after 4 bits -> outputs (10,8,0,0,0); subsequent 8-bit frame decodes from bit 0; back-to-back frames with zero gap -> two frame_valid pulses 8 cycles apart.
